// File: rtl/quad_word_gather.sv
// rtl/quad_word_gather.sv - gathers four serial words into one parallel four-lane group
module quad_word_gather #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       count
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t state;

    logic in_xfer;
    logic out_xfer;

    // A full group can be replaced in the same cycle it drains, so input
    // readiness in FULL follows the downstream enable.
    always_comb begin
        out_valid = (state == FULL);
        in_ready  = (state == COLLECT) || out_ready;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // Group assembly: lane selection by count, drain/refill when FULL, flush overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            count <= 3'd0;
            out_1 <= '0;
            out_2 <= '0;
            out_3 <= '0;
            out_4 <= '0;
        end else if (flush) begin
            state <= COLLECT;
            count <= 3'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        case (count[1:0])
                            2'd0:    out_1 <= in_data;
                            2'd1:    out_2 <= in_data;
                            2'd2:    out_3 <= in_data;
                            default: out_4 <= in_data;
                        endcase
                        count <= count + 3'd1;
                        if (count == 3'd3) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state <= COLLECT;
                        if (in_xfer) begin
                            out_1 <= in_data;
                            count <= 3'd1;
                        end else begin
                            count <= 3'd0;
                        end
                    end
                end
                default: begin
                    state <= COLLECT;
                    count <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_word_gather.sv
// tb/tb_quad_word_gather.sv - directed and randomized-gap checks for quad_word_gather
module tb_quad_word_gather;

    localparam int WIDTH = 32;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] out_1;
    logic [WIDTH-1:0] out_2;
    logic [WIDTH-1:0] out_3;
    logic [WIDTH-1:0] out_4;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       count;

    int n_tests;
    int n_fail;

    quad_word_gather #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_4     (out_4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        check({tag, ".out_1"}, out_1, a);
        check({tag, ".out_2"}, out_2, b);
        check({tag, ".out_3"}, out_3, c);
        check({tag, ".out_4"}, out_4, d);
    endtask

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] e1, e2, e3, e4;
    int               pushed;
    int               groups;
    int               max_count;
    int               cycles;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        clk_en    = 1'b1;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst.count", count, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check_lanes("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back group with downstream always ready
        out_ready = 1'b1;
        send(32'h11);
        send(32'h22);
        send(32'h33);
        check("b2b.count3", count, 3);
        check("b2b.valid_early", out_valid, 0);
        send(32'h44);
        check("b2b.out_valid", out_valid, 1);
        check("b2b.count4", count, 4);
        check_lanes("b2b", 32'h11, 32'h22, 32'h33, 32'h44);
        tick();
        check("b2b.valid_one_cycle", out_valid, 0);
        check("b2b.count0", count, 0);

        // Back-pressure while full, then simultaneous drain and refill
        out_ready = 1'b0;
        send(32'h01);
        send(32'h02);
        send(32'h03);
        send(32'h04);
        in_valid = 1'b1;
        in_data  = 32'h77;
        for (int i = 0; i < 5; i++) begin
            check("bp.in_ready", in_ready, 0);
            check("bp.out_valid", out_valid, 1);
            check_lanes("bp", 32'h01, 32'h02, 32'h03, 32'h04);
            tick();
        end
        out_ready = 1'b1;
        in_data   = 32'h55;
        #1;
        check("bp.in_ready_follow", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("refill.count", count, 1);
        check("refill.out_1", out_1, 32'h55);
        check("refill.out_valid", out_valid, 0);

        // Flush with a word presented: word dropped, next group clean
        send(32'h66);
        check("pre_flush.count", count, 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h99;
        #1;
        check("flush.in_ready", in_ready, 1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.count", count, 0);
        check("flush.out_valid", out_valid, 0);
        send(32'hA1);
        send(32'hA2);
        send(32'hA3);
        send(32'hA4);
        check("post_flush.out_valid", out_valid, 1);
        check_lanes("post_flush", 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        out_ready = 1'b1;
        tick();
        check("post_flush.drain", count, 0);
        out_ready = 1'b0;

        // Asynchronous reset with the clock stopped mid-group
        send(32'hB1);
        send(32'hB2);
        send(32'hB3);
        @(negedge clk);
        clk_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.count", count, 0);
        check("arst.out_valid", out_valid, 0);
        check_lanes("arst", 0, 0, 0, 0);
        #2;
        rst_n  = 1'b1;
        #2;
        clk_en = 1'b1;
        tick();
        send(32'hA);
        send(32'hB);
        send(32'hC);
        send(32'hD);
        check("arst.group_valid", out_valid, 1);
        check_lanes("arst_group", 32'hA, 32'hB, 32'hC, 32'hD);
        out_ready = 1'b1;
        tick();
        check("arst.drain", count, 0);

        // Random in_valid/out_ready gaps over 1000 words
        pushed    = 0;
        groups    = 0;
        max_count = 0;
        cycles    = 0;
        next_word = 32'h1000;
        while ((pushed < 1000 || groups < 250) && cycles < 20000) begin
            in_valid  = (pushed < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = next_word;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (int'(count) > max_count) max_count = int'(count);
            if (out_valid && out_ready) begin
                e1 = exp_q.pop_front();
                e2 = exp_q.pop_front();
                e3 = exp_q.pop_front();
                e4 = exp_q.pop_front();
                check_lanes("rand", e1, e2, e3, e4);
                groups++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(next_word);
                next_word = next_word + 32'h1;
                pushed++;
            end
            tick();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand.words", pushed, 1000);
        check("rand.groups", groups, 250);
        check("rand.leftover", exp_q.size(), 0);
        check("rand.max_count_le4", (max_count <= 4), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_word_gather.md
QUAD_WORD_GATHER -- requirements
Module: quad_word_gather

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each data word and each output lane.
REQ-002 clock  input  1  sole clock; every state element updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clock.
REQ-004 in_data  input  WIDTH  serial word from upstream.
REQ-005 in_valid  input  1  upstream has a word on in_data.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 flush  input  1  synchronous discard of any partial or complete group.
REQ-008 out_1, out_2, out_3, out_4  output  WIDTH each  assembled group, in arrival order (out_1 = first word).
REQ-009 out_valid  output  1  out_1..out_4 hold a complete group.
REQ-010 out_ready  input  1  downstream four-word register accepts the group (drives its enable).
REQ-011 count  output  3  number of words currently held, 0..4.

Function
REQ-012 Input transfer occurs on a rising edge when in_valid=1 and in_ready=1; output transfer occurs on a rising edge when out_valid=1 and out_ready=1.
REQ-013 State machine has two states: COLLECT (count 0..3) and FULL (count=4).
REQ-014 In COLLECT, in_ready=1 and out_valid=0.
REQ-015 In FULL, out_valid=1 and in_ready=out_ready.
REQ-016 In COLLECT, an input transfer stores in_data into lane count+1 and increments count.
REQ-017 When the fourth word is accepted, the state becomes FULL on that edge, so out_valid is high the following cycle (latency of one cycle from the fourth transfer).
REQ-018 In FULL, an output transfer with no simultaneous input transfer returns the state to COLLECT with count=0.
REQ-019 In FULL, simultaneous output and input transfers return the state to COLLECT with count=1 and store the new word in out_1.
REQ-020 out_1..out_4 remain stable while out_valid=1 and out_ready=0; input is back-pressured (in_ready=0) during that time.
REQ-021 Lanes not yet written in the current group hold their previous values, which are don't-care while out_valid=0.
REQ-022 flush=1 has priority over every transfer: on the next edge count=0, state=COLLECT, out_valid=0, and any in_data presented that cycle is dropped.
REQ-023 While flush=1, in_ready shall remain per REQ-014/REQ-015, and the dropped word shall still count as consumed by upstream.
REQ-024 An in_valid=0 cycle leaves all state unchanged; in_data is ignored when in_valid=0.
REQ-025 count equals the number of lanes written in the current group, and reads 4 exactly when out_valid=1.

Reset
REQ-026 While reset=0: state=COLLECT, count=0, out_valid=0, in_ready=1, and out_1..out_4 are all zero.
REQ-027 Reset asserted mid-group or while FULL discards the group with no output transfer; the first transfer after release fills out_1.

Verification
REQ-028 Four back-to-back words 0x11,0x22,0x33,0x44 with out_ready=1 -> out_valid high for exactly one cycle, the cycle after the 0x44 transfer, with out_1..out_4=0x11,0x22,0x33,0x44 and count=4.
REQ-029 Group complete and out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout and outputs stable; out_ready=1 with in_data=0x55 -> next cycle count=1, out_1=0x55, out_valid=0.
REQ-030 Two words accepted, then flush=1 with in_valid=1 and in_data=0x99 -> count=0 next cycle and 0x99 absent; the next four words form a clean group.
REQ-031 reset low after three words, while clock is stopped -> count=0, out_valid=0 and outputs zero immediately; after release, words 0xA..0xD yield out_1=0xA.
REQ-032 Random in_valid/out_ready gaps over 1000 words -> every group is delivered in order, with no loss or duplication, and count never exceeds 4.
